// File: rtl/pipe_pkg.sv
// Shared definitions for the two-lane pipe serializer: default word width,
// serializer FSM states and the pass-through codes flagged on the output.
package pipe_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [15:0] PT_ZERO = 16'h0000;
  localparam logic [15:0] PT_ONES = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LANE0 = 2'd1,
    LANE1 = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_pair_fifo.sv
// Circular FIFO of sample pairs with occupancy count. DEPTH must be a power
// of two so the pointers wrap by natural binary overflow.
module pipe_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // NOTE: the storage array is deliberately not reset; level_q alone decides
  // which entries are meaningful, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i && !pop_i)      level_d = level_q + LVL_W'(1);
    else if (!push_i && pop_i) level_d = level_q - LVL_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/pipe_serializer.sv
// Serializes corrected two-lane sample pairs into a single word stream
// (lane 0 then lane 1) with FIFO buffering and a sticky drop flag.
module pipe_serializer
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_data0,
  input  logic [DATA_W-1:0]             i_data1,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_lane,
  output logic                          o_sat,
  output logic [$clog2(DEPTH+1)-1:0]    o_level,
  output logic                          o_ovf,
  input  logic                          i_ovf_clr
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  state_t              state_q, state_d;
  logic                ovf_q, ovf_d;
  logic [2*DATA_W-1:0] head;
  logic                full, empty;
  logic [LVL_W-1:0]    level;
  logic                xfer, pop, push, drop;

  assign xfer = o_valid && i_ready;
  assign pop  = xfer && (state_q == LANE1);
  // A full FIFO can still take a pair when the head pair leaves on this edge.
  assign push = i_valid && (!full || pop);
  assign drop = i_valid && !push;

  pipe_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({i_data1, i_data0}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!empty || push) state_d = LANE0;
      LANE0: if (xfer) state_d = LANE1;
      LANE1: if (xfer) state_d = (push || level > LVL_W'(1)) ? LANE0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_valid = 1'b0;
    o_lane  = 1'b0;
    o_data  = '0;
    unique case (state_q)
      LANE0: begin
        o_valid = 1'b1;
        o_data  = head[DATA_W-1:0];
      end
      LANE1: begin
        o_valid = 1'b1;
        o_lane  = 1'b1;
        o_data  = head[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  assign o_sat = o_valid &&
                 ((o_data == DATA_W'(PT_ZERO)) || (o_data == DATA_W'(PT_ONES)));

  // A drop on the same edge as a clear must leave the flag set.
  assign ovf_d = drop ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_level = level;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_serializer.sv
// Scoreboard bench for pipe_serializer: directed scenarios plus random traffic
// checked against a queue-of-words reference model.
module tb_pipe_serializer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_valid, i_ready, i_ovf_clr;
  logic [DATA_W-1:0] i_data0, i_data1;
  logic [DATA_W-1:0] o_data;
  logic              o_valid, o_lane, o_sat, o_ovf;
  logic [$clog2(DEPTH+1)-1:0] o_level;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              lane;
  } word_t;

  word_t exp_q[$];
  bit    m_ovf;
  int    checks;
  int    errors;

  pipe_serializer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_data0   (i_data0),
    .i_data1   (i_data1),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_lane    (o_lane),
    .o_sat     (o_sat),
    .o_level   (o_level),
    .o_ovf     (o_ovf),
    .i_ovf_clr (i_ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_pt(input logic [DATA_W-1:0] w);
    return (w == 16'h0000) || (w == 16'hFFFF);
  endfunction

  // Pairs stored = words still owed, rounded up (a half-sent pair still counts).
  function automatic int model_level();
    return (exp_q.size() + 1) / 2;
  endfunction

  // Monitor: outputs seen here belong to the previous edge; i_ready is already
  // the value for the coming edge, so a presented word transfers iff it is set.
  always @(negedge clk) begin
    if (rst_n) begin
      check("level", 32'(o_level), 32'(model_level()));
      check("ovf", 32'(o_ovf), 32'(m_ovf));
      if (exp_q.size() > 0) begin
        check("valid", 32'(o_valid), 32'd1);
        check("data", 32'(o_data), 32'(exp_q[0].data));
        check("lane", 32'(o_lane), 32'(exp_q[0].lane));
        check("sat", 32'(o_sat), 32'(is_pt(exp_q[0].data)));
        if (i_ready) void'(exp_q.pop_front());
      end else begin
        check("valid_idle", 32'(o_valid), 32'd0);
        check("sat_idle", 32'(o_sat), 32'd0);
      end
    end
  end

  // Drives one edge's worth of inputs and predicts its effect on the model.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                       input logic rdy, input logic clr);
    bit pop_now, full_now, acc, drop;
    i_valid   = v;
    i_data0   = d0;
    i_data1   = d1;
    i_ready   = rdy;
    i_ovf_clr = clr;
    pop_now   = rdy && (exp_q.size() > 0) && exp_q[0].lane;
    full_now  = (model_level() == DEPTH);
    acc       = v && (!full_now || pop_now);
    drop      = v && !acc;
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back('{data: d0, lane: 1'b0});
      exp_q.push_back('{data: d1, lane: 1'b1});
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic reset_checks();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_lane", 32'(o_lane), 32'd0);
    check("rst_sat", 32'(o_sat), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    i_ovf_clr = 1'b0;
    #1;
    reset_checks();
    exp_q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return 16'h0000;
    if (sel == 1) return 16'hFFFF;
    return DATA_W'($urandom);
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    m_ovf     = 1'b0;
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    i_ovf_clr = 1'b0;
    i_data0   = '0;
    i_data1   = '0;
    #1;
    reset_checks();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single pair through an empty FIFO, push on the first edge after reset.
    cycle(1'b1, 16'h1234, 16'h00FF, 1'b1, 1'b0);
    drain(4);

    // Backpressure holds lane 0 stable, then lane 1 follows.
    cycle(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    drain(4);

    // Overflow: fifth pair is dropped, then the sticky flag is cleared.
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 16'(16'h0100 + k), 16'(16'h0200 + k), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Full with pop: LANE0 -> LANE1, then push coincides with the pop.
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'hBEEF, 16'hCAFE, 1'b1, 1'b0);
    drain(12);

    // Pass-through flag on and off.
    cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0001, 16'hFFFE, 1'b1, 1'b0);
    drain(4);

    // Drop and clear on the same edge: the drop wins.
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 16'(16'h0300 + k), 16'(16'h0400 + k), 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    drain(10);

    // Reset in LANE1 with three pairs stored.
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 16'(16'h0500 + k), 16'(16'h0600 + k), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("lvl_before_rst", 32'(o_level), 32'd3);
    check("lane_before_rst", 32'(o_lane), 32'd1);
    do_reset();
    cycle(1'b1, 16'h7777, 16'h8888, 1'b1, 1'b0);
    cycle(1'b1, 16'h9999, 16'hABCD, 1'b1, 1'b0);
    drain(6);

    // Random traffic.
    for (int k = 0; k < 800; k++)
      cycle(1'($urandom_range(0, 1)), rand_word(), rand_word(),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 15) == 0));
    drain(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_serializer.md
PIPE_SERIALIZER -- requirements
Module: pipe_serializer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO capacity in sample pairs; SHALL be a power of two in the range 2..16.
REQ-002 Parameter DATA_W, default 16, lane word width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 i_valid  input  1  a pair is present on i_data0/i_data1 this cycle; there is no upstream backpressure.
REQ-006 i_data0  input  DATA_W  lane-0 corrected sample from the upstream pipe stage.
REQ-007 i_data1  input  DATA_W  lane-1 corrected sample from the upstream pipe stage.
REQ-008 o_data  output  DATA_W  serialized word.
REQ-009 o_valid  output  1  o_data is valid.
REQ-010 i_ready  input  1  downstream accepts o_data.
REQ-011 o_lane  output  1  lane of the current word: 0 = data0, 1 = data1.
REQ-012 o_sat  output  1  current o_data equals 16'h0000 or 16'hFFFF (pass-through code).
REQ-013 o_level  output  $clog2(DEPTH+1)  number of pairs stored.
REQ-014 o_ovf  output  1  sticky flag: a pair was dropped.
REQ-015 i_ovf_clr  input  1  clears o_ovf.

Function
REQ-016 Push: a pair SHALL be accepted on an edge with i_valid=1 when o_level<DEPTH or when a pop occurs on the same edge.
REQ-017 Full drop: when i_valid=1, o_level=DEPTH and no pop occurs, the pair SHALL be discarded, o_level SHALL be unchanged and o_ovf SHALL set.
REQ-018 Transfer: a transfer SHALL occur on an edge where o_valid=1 and i_ready=1.
REQ-019 FSM states: IDLE, LANE0, LANE1.
REQ-020 IDLE SHALL go to LANE0 when o_level!=0 or an accepted push occurs; otherwise it SHALL stay in IDLE.
REQ-021 LANE0 SHALL go to LANE1 on a transfer and hold otherwise.
REQ-022 LANE1 on a transfer SHALL pop the head pair; it SHALL go to LANE0 if pairs remain after the pop (counting a simultaneous push), else to IDLE; otherwise it SHALL hold.
REQ-023 o_valid SHALL be 1 exactly in LANE0/LANE1; o_data SHALL be head.data0 in LANE0 and head.data1 in LANE1; o_lane SHALL be 0 in LANE0 and 1 in LANE1.
REQ-024 Latency: a pair pushed into an empty FIFO at edge N SHALL have o_valid=1 with lane 0 in the cycle after edge N.
REQ-025 Throughput: with i_ready held at 1, one word SHALL transfer per cycle, i.e. two cycles per pair.
REQ-026 Stability: while o_valid=1 and i_ready=0, o_data, o_lane and o_sat SHALL hold stable.
REQ-027 Simultaneous push and pop SHALL leave o_level unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 o_ovf: i_ovf_clr SHALL clear it; when a drop and i_ovf_clr coincide, the set SHALL win.
REQ-030 o_sat SHALL be combinational from o_data and SHALL be 0 when o_valid=0.
REQ-031 The block SHALL perform no data arithmetic; words SHALL pass through bit-exact.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, pointers 0, o_level 0, o_valid 0, o_data 0, o_lane 0, o_sat 0, o_ovf 0.
REQ-033 Reset mid-operation SHALL discard all stored pairs, including a half-sent pair, with no partial word after release.
REQ-034 The first edge after reset release SHALL be able to accept a push.

Structure
REQ-035 Shared package pipe_pkg SHALL hold the DATA_W default, the FSM state typedef (IDLE/LANE0/LANE1) and the pass-through constants 16'h0000 and 16'hFFFF.
REQ-036 Pair storage SHALL be the sub-module pipe_pair_fifo (2*DATA_W wide, DEPTH deep, push/pop/full/empty/level); the FSM and flags SHALL live in the top module.

Verification
REQ-037 Single pair: push (0x1234,0x00FF), i_ready=1 -> o_data 0x1234 with lane 0 the next cycle, then 0x00FF with lane 1; then o_valid=0 and o_level=0.
REQ-038 Backpressure: push (0xAAAA,0x5555), i_ready=0 for 5 cycles -> o_data holds 0xAAAA with o_valid=1; after i_ready=1, 0x5555 follows.
REQ-039 Overflow: DEPTH=4, i_ready=0, push 5 pairs -> o_level=4, o_ovf=1, pair 5 absent from the output; assert i_ovf_clr -> o_ovf=0.
REQ-040 Full with pop: o_level=4 in LANE1 with i_ready=1 and i_valid=1 -> pair accepted, o_level stays 4, o_ovf stays 0.
REQ-041 Pass-through flag: push (0xFFFF,0x0000) -> o_sat=1 on both words; push (0x0001,0xFFFE) -> o_sat=0 on both.
REQ-042 Reset mid-stream: assert rst_n=0 while in LANE1 with o_level=3 -> o_valid=0 and o_level=0 immediately; after release, only newly pushed pairs appear.
